// File: rtl/iv_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iv_audio_pkg
//  Description : Shared audio types for the melody sequencer and oscillator:
//                note index type, sequence table entry and sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package iv_audio_pkg;

    localparam int NOTE_W = 5;
    localparam int DUR_W  = 4;

    typedef logic [NOTE_W-1:0] note_t;

    // Note code 0 is silence
    localparam note_t NOTE_REST = '0;

    typedef struct packed {
        note_t            note;
        logic [DUR_W-1:0] dur;
    } seq_entry_t;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t c_st_idle  = 3'd0;
    localparam seq_state_t c_st_fetch = 3'd1;
    localparam seq_state_t c_st_play  = 3'd2;
    localparam seq_state_t c_st_gap   = 3'd3;
    localparam seq_state_t c_st_end   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/note_sequencer_seq_ram.sv
`default_nettype none
// ============================================================================
//  Module      : seq_ram
//  Description : Melody table storage. Synchronous write, registered read,
//                read-before-write on a same-address collision. No reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_ram
    import iv_audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  seq_entry_t    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output seq_entry_t    o_rdata
);

    seq_entry_t r_mem [DEPTH];
    seq_entry_t r_rdata;

    // Table write and registered read; the read sees the pre-write contents
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer
//  Description : Melody sequencer feeding the oscillator. Walks a table of
//                {note, duration} entries at a fixed tempo, emitting a load
//                strobe with each new note, optional rest gaps, one-shot or
//                looped playback.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import iv_audio_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000,
    parameter int SEQ_DEPTH   = 16,
    parameter int GAP_TICKS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_en,
    input  logic                         prog_we,
    input  logic [$clog2(SEQ_DEPTH)-1:0] prog_addr,
    input  note_t                        prog_note,
    input  logic [DUR_W-1:0]             prog_dur,
    output logic                         load,
    output note_t                        note,
    output logic                         busy,
    output logic                         done
);

    localparam int c_aw = $clog2(SEQ_DEPTH);
    localparam int c_pw = $clog2(TICK_CYCLES);

    localparam logic [c_pw-1:0]  c_presc_last = c_pw'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0] c_gap_last   = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [c_aw-1:0]  c_addr_last  = c_aw'(SEQ_DEPTH - 1);
    localparam bit               c_has_gap    = (GAP_TICKS > 0);

    seq_state_t       r_state;
    logic [c_aw-1:0]  r_addr;
    logic [c_pw-1:0]  r_presc;
    logic [DUR_W-1:0] r_ticks;
    logic [DUR_W-1:0] r_dur_last;
    logic             r_load;
    note_t            r_note;
    logic             r_busy;
    logic             r_done;

    logic [c_aw-1:0]  w_addr_next;
    seq_entry_t       w_rd_entry;
    seq_entry_t       w_wr_entry;
    logic             w_ram_we;
    logic             w_abort;
    logic             w_tick_wrap;
    logic             w_play_last;
    logic             w_gap_last;
    logic             w_seg_done;
    logic             w_advance;

    assign w_ram_we    = prog_we && !r_busy;
    assign w_wr_entry  = '{note: prog_note, dur: prog_dur};

    assign w_abort     = stop && (r_state != c_st_idle);
    assign w_tick_wrap = (r_presc == c_presc_last);
    assign w_play_last = w_tick_wrap && (r_ticks == r_dur_last);
    assign w_gap_last  = w_tick_wrap && (r_ticks == c_gap_last);
    assign w_seg_done  = ((r_state == c_st_play) && w_play_last) ||
                         ((r_state == c_st_gap)  && w_gap_last);
    // Leaving the current entry: end of the note when there is no gap,
    // otherwise end of the rest gap that follows it
    assign w_advance   = !w_abort &&
                         (((r_state == c_st_play) && w_play_last && !c_has_gap) ||
                          ((r_state == c_st_gap)  && w_gap_last));

    // The RAM is addressed with the next address so the entry is ready in FETCH
    always_comb begin
        w_addr_next = r_addr;
        if (!w_abort) begin
            case (r_state)
                c_st_idle: if (start && !stop) w_addr_next = '0;
                c_st_end:  if (loop_en)        w_addr_next = '0;
                default:   if (w_advance)      w_addr_next = r_addr + c_aw'(1);
            endcase
        end
    end

    seq_ram #(
        .DEPTH (SEQ_DEPTH),
        .AW    (c_aw)
    ) u_seq_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (prog_addr),
        .i_wdata (w_wr_entry),
        .i_raddr (w_addr_next),
        .o_rdata (w_rd_entry)
    );

    // Tempo prescaler and tick counter, running only while a note or gap sounds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_ticks <= '0;
        end else if (((r_state == c_st_play) || (r_state == c_st_gap)) &&
                     !w_abort && !w_seg_done) begin
            if (w_tick_wrap) begin
                r_presc <= '0;
                r_ticks <= r_ticks + DUR_W'(1);
            end else begin
                r_presc <= r_presc + c_pw'(1);
            end
        end else begin
            r_presc <= '0;
            r_ticks <= '0;
        end
    end

    // Playback state machine and registered oscillator-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_dur_last <= '0;
            r_load     <= 1'b0;
            r_note     <= NOTE_REST;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_addr <= w_addr_next;
            r_load <= 1'b0;
            r_done <= 1'b0;
            if (w_abort) begin
                r_load  <= 1'b1;
                r_note  <= NOTE_REST;
                r_busy  <= 1'b0;
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start && !stop) begin
                            r_busy  <= 1'b1;
                            r_state <= c_st_fetch;
                        end
                    end
                    c_st_fetch: begin
                        if (w_rd_entry.dur != '0) begin
                            r_load     <= 1'b1;
                            r_note     <= w_rd_entry.note;
                            r_dur_last <= w_rd_entry.dur - DUR_W'(1);
                            r_state    <= c_st_play;
                        end else begin
                            r_state <= c_st_end;
                        end
                    end
                    c_st_play: begin
                        if (w_play_last) begin
                            if (c_has_gap) begin
                                r_load  <= 1'b1;
                                r_note  <= NOTE_REST;
                                r_state <= c_st_gap;
                            end else if (r_addr == c_addr_last) begin
                                r_state <= c_st_end;
                            end else begin
                                r_state <= c_st_fetch;
                            end
                        end
                    end
                    c_st_gap: begin
                        if (w_gap_last) begin
                            r_state <= (r_addr == c_addr_last) ? c_st_end : c_st_fetch;
                        end
                    end
                    c_st_end: begin
                        if (loop_en) begin
                            r_state <= c_st_fetch;
                        end else begin
                            r_load  <= 1'b1;
                            r_note  <= NOTE_REST;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign load = r_load;
    assign note = r_note;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_sequencer
//  Description : Bench for note_sequencer. Two instances (with and without the
//                articulation gap) share stimulus; a timeline model predicts
//                every output cycle of each playback run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

    localparam int TICK  = 4;
    localparam int DEPTH = 4;
    localparam int HMAX  = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic       prog_we = 1'b0;
    logic [1:0] prog_addr = '0;
    logic [4:0] prog_note = '0;
    logic [3:0] prog_dur = '0;

    logic       ld [2];
    logic [4:0] nt [2];
    logic       bs [2];
    logic       dn [2];

    note_sequencer #(.TICK_CYCLES(TICK), .SEQ_DEPTH(DEPTH), .GAP_TICKS(1)) u_dut_gap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_note(prog_note), .prog_dur(prog_dur),
        .load(ld[0]), .note(nt[0]), .busy(bs[0]), .done(dn[0]));

    note_sequencer #(.TICK_CYCLES(TICK), .SEQ_DEPTH(DEPTH), .GAP_TICKS(0)) u_dut_nogap (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_note(prog_note), .prog_dur(prog_dur),
        .load(ld[1]), .note(nt[1]), .busy(bs[1]), .done(dn[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Melody table as the bench believes it is programmed
    int tnote [DEPTH];
    int tdur  [DEPTH];
    int cur_note [2];

    // Expected outputs per run-relative cycle, index 1 = cycle after start is sampled
    bit e_ld [2][0:HMAX];
    int e_nt [2][0:HMAX];
    bit e_bs [2][0:HMAX];
    bit e_dn [2][0:HMAX];

    int run_base = 0;
    int run_len  = 0;
    bit run_on   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Timeline model: walk the table entry by entry, placing note loads, rests,
    // end-of-sequence and stop effects at absolute run-relative cycles.
    task automatic model(input int g, input int gap, input bit lp, input int stop_rel,
                         output int busy_end);
        bit l  [0:HMAX];
        int ln [0:HMAX];
        bit d  [0:HMAX];
        int t, idx, endc, nx, n;
        bit fin;
        for (int k = 0; k <= HMAX; k++) begin
            l[k] = 1'b0; ln[k] = 0; d[k] = 1'b0;
        end
        t = 1; idx = 0; fin = 1'b0; busy_end = HMAX + 1;
        while (!fin && t < HMAX) begin
            endc = -1;
            if (tdur[idx] == 0) begin
                endc = t + 1;
            end else begin
                if (t + 1 <= HMAX) begin l[t+1] = 1'b1; ln[t+1] = tnote[idx]; end
                nx = t + 1 + tdur[idx] * TICK;
                if (gap > 0) begin
                    if (nx <= HMAX) begin l[nx] = 1'b1; ln[nx] = 0; end
                    nx = nx + gap * TICK;
                end
                if (idx == DEPTH - 1) endc = nx;
                else begin idx++; t = nx; end
            end
            if (endc >= 0) begin
                if (lp) begin
                    t = endc + 1; idx = 0;
                end else begin
                    if (endc + 1 <= HMAX) begin
                        l[endc+1] = 1'b1; ln[endc+1] = 0; d[endc+1] = 1'b1;
                    end
                    busy_end = endc + 1;
                    fin = 1'b1;
                end
            end
        end
        if (stop_rel >= 1 && stop_rel < busy_end && stop_rel < HMAX) begin
            for (int k = stop_rel + 1; k <= HMAX; k++) begin
                l[k] = 1'b0; d[k] = 1'b0;
            end
            l[stop_rel+1] = 1'b1; ln[stop_rel+1] = 0;
            busy_end = stop_rel + 1;
        end
        n = cur_note[g];
        for (int k = 0; k <= HMAX; k++) begin
            if (l[k]) n = ln[k];
            e_ld[g][k] = l[k];
            e_nt[g][k] = n;
            e_dn[g][k] = d[k];
            e_bs[g][k] = (k >= 1) && (k < busy_end);
        end
        cur_note[g] = n;
    endtask

    // Per-cycle comparison of both instances against the model during a run
    always @(negedge clk) begin
        int k;
        k = cyc - run_base;
        if (run_on && k >= 1 && k <= run_len) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("load[%0d]@%0d", g, k), {31'd0, ld[g]}, int'(e_ld[g][k]));
                chk($sformatf("note[%0d]@%0d", g, k), {27'd0, nt[g]}, e_nt[g][k]);
                chk($sformatf("busy[%0d]@%0d", g, k), {31'd0, bs[g]}, int'(e_bs[g][k]));
                chk($sformatf("done[%0d]@%0d", g, k), {31'd0, dn[g]}, int'(e_dn[g][k]));
            end
        end
    end

    task automatic prog(input int a, input int n, input int d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 2'(a); prog_note = 5'(n); prog_dur = 4'(d);
        @(negedge clk);
        prog_we = 1'b0;
        tnote[a] = n; tdur[a] = d;
    endtask

    task automatic do_run(input bit lp, input int stop_rel, input bit noise);
        int be0, be1;
        @(negedge clk);
        model(0, 1, lp, stop_rel, be0);
        model(1, 0, lp, stop_rel, be1);
        run_base = cyc;
        run_len  = ((be0 > be1) ? be0 : be1) + 4;
        if (run_len > HMAX) run_len = HMAX;
        loop_en = lp;
        start   = 1'b1;
        run_on  = 1'b1;
        for (int k = 1; k <= run_len; k++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0; prog_we = 1'b0;
            if (k == stop_rel) begin
                stop = 1'b1;
            end else if (noise && e_bs[0][k] && e_bs[1][k] && ($urandom_range(0, 7) == 0)) begin
                if ($urandom_range(0, 1) == 0) begin
                    start = 1'b1;
                end else begin
                    prog_we   = 1'b1;
                    prog_addr = 2'($urandom_range(0, 3));
                    prog_note = 5'($urandom_range(0, 31));
                    prog_dur  = 4'($urandom_range(0, 15));
                end
            end
        end
        @(posedge clk);
        run_on = 1'b0;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; prog_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int sr;
        cur_note[0] = 0; cur_note[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset_load[%0d]", g), {31'd0, ld[g]}, 0);
            chk($sformatf("reset_note[%0d]", g), {27'd0, nt[g]}, 0);
            chk($sformatf("reset_busy[%0d]", g), {31'd0, bs[g]}, 0);
            chk($sformatf("reset_done[%0d]", g), {31'd0, dn[g]}, 0);
        end

        // Reference melody {(5,2),(9,1),end}
        prog(0, 5, 2); prog(1, 9, 1); prog(2, 0, 0); prog(3, 7, 3);

        // Reset in the middle of the first note
        @(negedge clk);
        loop_en = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("midplay_load", {31'd0, ld[0]}, 1);
        chk("midplay_note", {27'd0, nt[0]}, 5);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_mid_load[%0d]", g), {31'd0, ld[g]}, 0);
            chk($sformatf("rst_mid_note[%0d]", g), {27'd0, nt[g]}, 0);
            chk($sformatf("rst_mid_busy[%0d]", g), {31'd0, bs[g]}, 0);
            chk($sformatf("rst_mid_done[%0d]", g), {31'd0, dn[g]}, 0);
        end
        rst = 1'b0;
        cur_note[0] = 0; cur_note[1] = 0;

        // One-shot reference melody, with literal pins on the model timeline
        do_run(1'b0, -1, 1'b0);
        chk("pin_g1_load5",  int'(e_ld[0][2]), 1);
        chk("pin_g1_note5",  e_nt[0][2], 5);
        chk("pin_g1_rest10", int'(e_ld[0][10]), 1);
        chk("pin_g1_note9",  e_nt[0][15], 9);
        chk("pin_g1_rest19", int'(e_ld[0][19]), 1);
        chk("pin_g1_done25", int'(e_dn[0][25]), 1);
        chk("pin_g1_busy24", int'(e_bs[0][24]), 1);
        chk("pin_g0_note9",  e_nt[1][11], 9);
        chk("pin_g0_done17", int'(e_dn[1][17]), 1);

        // Looped reference melody, stopped mid-note
        do_run(1'b1, 30, 1'b0);
        chk("pin_loop_reload", e_nt[0][26], 5);
        chk("pin_stop_load",   int'(e_ld[0][31]), 1);
        chk("pin_stop_busy",   int'(e_bs[0][31]), 0);

        // Full table: address wrap ends the sequence
        prog(0, 3, 1); prog(1, 4, 2); prog(2, 6, 1); prog(3, 8, 3);
        do_run(1'b0, -1, 1'b0);
        chk("pin_wrap_g1_done", int'(e_dn[0][50]), 1);
        chk("pin_wrap_g0_done", int'(e_dn[1][34]), 1);
        chk("pin_wrap_g0_norest", int'(e_ld[1][6]), 0);
        do_run(1'b1, 120, 1'b1);

        // Empty sequence, one-shot and looped
        prog(0, 12, 0);
        do_run(1'b0, -1, 1'b0);
        chk("pin_empty_done3", int'(e_dn[0][3]), 1);
        chk("pin_empty_noload2", int'(e_ld[0][2]), 0);
        do_run(1'b1, 20, 1'b0);

        // start and stop together from IDLE
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("startstop_busy[%0d]", g), {31'd0, bs[g]}, 0);
            chk($sformatf("startstop_load[%0d]", g), {31'd0, ld[g]}, 0);
        end
        @(negedge clk);
        chk("startstop_busy_late", {31'd0, bs[0]}, 0);

        // Randomized tables and playback modes with busy-time noise
        for (int it = 0; it < 24; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                prog(a, $urandom_range(1, 31),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6));
            end
            if ($urandom_range(0, 1) == 1) begin
                do_run(1'b1, $urandom_range(1, 250), 1'b1);
            end else begin
                sr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 120) : -1;
                do_run(1'b0, sr, 1'b1);
            end
            // Replay untouched by stop to expose any write that slipped through
            do_run(1'b0, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
